itp_pixel_source: RTL and testbench
===================================

// Module: itp_pixel_source
// PURPOSE
//  Producer end of the interpolation read-request interface. Buffers camera pixels (write side) in a FIFO.
//  Kicks the interpolation consumer with a 1-cycle start pulse once prefilled.
//  Answers each consumer read request with one RGB pixel, registered, at fixed 1-cycle latency.
//  Sits between the capture/SDRAM path and the interpolation/VGA timing block.
// PARAMETERS
//  DEPTH       1024  FIFO depth in pixels (power of 2)
//  PREFILL_LVL 512   FIFO level that ends prefill (1..DEPTH)
//  CW          10    bits per colour channel
// PORTS
//  i_clk          in   1       clock
//  i_rst_n        in   1       reset, asynchronous, active-low
//  i_wr_valid     in   1       write pixel valid
//  i_sof          in   1       qualifies i_wr_valid pixel as first pixel of a frame
//  i_wr_R/G/B     in   CW each write pixel colour
//  i_read_request in   1       consumer pops one pixel
//  i_finish       in   1       consumer frame done (1-cycle pulse)
//  i_clr_err      in   1       clears sticky error flags
//  o_start        out  1       1-cycle pulse: consumer may begin frame
//  o_Red/Green/Blue out CW each  served pixel (registered)
//  o_level        out  clog2(DEPTH)+1  FIFO occupancy
//  o_overflow     out  1       sticky: write dropped while full
//  o_underflow    out  1       sticky: read while empty
// BEHAVIOUR
//  Reset: state S_IDLE; FIFO empty; all outputs 0.
//  S_IDLE:
//   - Writes ignored unless i_sof & i_wr_valid.
//   - On that event: flush FIFO, write the sof pixel, go S_PREFILL.
//  S_PREFILL:
//   - Writes accepted; no reads served (i_read_request ignored, outputs 0).
//   - Level reaching >= PREFILL_LVL: o_start=1 next cycle only, go S_STREAM.
//  S_STREAM:
//   - Writes and reads both active.
//   - On i_finish: go S_IDLE and flush FIFO.
//  Any state, i_sof&i_wr_valid:
//   - Resync: flush, write the sof pixel, go S_PREFILL (re-prefills; no error flag).
//   - Takes priority over i_finish.
//  Read latency: i_read_request high in cycle n -> pixel on o_Red/Green/Blue in cycle n+1.
//   - Output is 0 in any cycle n+1 with no read in cycle n.
//  Full: write with level==DEPTH and no simultaneous read -> pixel dropped, o_overflow=1.
//   - Simultaneous read+write at full: both succeed; level unchanged.
//  Empty: read with level==0 -> o_underflow=1, underflow output (see CONFIGURATION).
//   - No write-to-read bypass: a same-cycle write is not readable.
//  Level arithmetic: +1 on accepted write, -1 on successful read, unchanged on both or neither.
//   - Pointers wrap modulo DEPTH.
//  Sticky flags: cleared by i_clr_err or on entry to S_PREFILL.
//   - A new error in the same cycle as i_clr_err wins (flag stays 1).
//  Reset mid-frame: immediate return to reset values; the consumer must re-wait o_start.
// CONFIGURATION
//  UNDERFLOW_REPEAT_EN defined: underflow read re-outputs the last successfully served pixel
//   (0 if none since flush).
//  Undefined: underflow read outputs 0/0/0.
//  o_underflow is set in both cases.
// STRUCTURE
//  Shared package itp_pkg: state encodings S_IDLE/S_PREFILL/S_STREAM; CW; pixel type {R,G,B} 3*CW.
//  Sub-module itp_pix_fifo:
//   - Synchronous single-clock FIFO with flush, level, full/empty.
//   - Registered read data; 1-cycle latency.
//  Top level holds the FSM, start pulse, error flags and output gating.
// TESTING
//  1 sof + 512 writes, DEPTH=1024 -> o_start pulses once, 1 cycle after level hits 512; state STREAM.
//  STREAM, write pixels 1,2,3 (R=G=B=k), read 3 consecutive cycles -> outputs 1,2,3 on cycles n+1..n+3; o_level 509.
//  Fill to 1024, write again with no read -> o_overflow=1, level 1024.
//   - Then read+write together -> level stays 1024.
//  Drain to 0, read once -> o_underflow=1, output 0; with UNDERFLOW_REPEAT_EN, last pixel repeated.
//  STREAM, i_sof pixel arrives -> level 1, state PREFILL, flags cleared, second o_start after 511 more writes.
//  Reset asserted mid-STREAM -> level 0, outputs 0, o_start 0.
//   - After release, reads ignored until the next sof + prefill.

Source files
------------

// File: rtl/itp_pkg.sv
// Shared definitions for the interpolation pixel source: FSM encoding,
// channel width and the packed RGB pixel type.
package itp_pkg;

    localparam int CW = 10;
    localparam int PW = 3 * CW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } pixel_t;

    function automatic pixel_t pack_pixel(input logic [CW-1:0] r,
                                          input logic [CW-1:0] g,
                                          input logic [CW-1:0] b);
        pixel_t p;
        p.r = r;
        p.g = g;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/itp_pix_fifo.sv
// Single-clock pixel FIFO with synchronous flush, occupancy level and a
// registered read port (data appears the cycle after a successful read).
module itp_pix_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 30
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_drop,
    output logic                     rd_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_addr;
    logic          full;
    logic          empty;
    logic          rd_ok;
    logic          wr_ok;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A read never sees a same-cycle write; a write at full only fits when a
    // read frees a slot in the same cycle. A flush always takes the write.
    assign rd_ok   = rd_en && !empty && !flush;
    assign wr_ok   = wr_en && (flush || !full || rd_ok);
    assign wr_drop = wr_en && !wr_ok;
    assign rd_fail = rd_en && empty && !flush;
    assign wr_addr = flush ? '0 : wr_ptr;

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= wr_ok ? AW'(1) : '0;
            rd_ptr <= '0;
            level  <= wr_ok ? LW'(1) : '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // rd_data holds the last served pixel between reads; a flush clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr];
            end else if (flush) begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/itp_pixel_source.sv
// Producer end of the interpolation read-request interface: FIFO prefill,
// start pulse, 1-cycle read service and sticky error flags.
// Optional UNDERFLOW_REPEAT_EN: an underflow read re-outputs the last served pixel.
module itp_pixel_source
    import itp_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int PREFILL_LVL = 512,
    parameter int CW          = itp_pkg::CW
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_valid,
    input  logic                   i_sof,
    input  logic [CW-1:0]          i_wr_R,
    input  logic [CW-1:0]          i_wr_G,
    input  logic [CW-1:0]          i_wr_B,
    input  logic                   i_read_request,
    input  logic                   i_finish,
    input  logic                   i_clr_err,
    output logic                   o_start,
    output logic [CW-1:0]          o_Red,
    output logic [CW-1:0]          o_Green,
    output logic [CW-1:0]          o_Blue,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    output logic                   o_underflow,
    output state_t                 o_state
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_t          state_q;
    state_t          state_d;
    logic            sof_evt;
    logic            fifo_flush;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            start_d;
    logic            start_q;
    logic [3*CW-1:0] fifo_rdata;
    logic            fifo_rvalid;
    logic [LW-1:0]   fifo_level;
    logic            wr_drop;
    logic            rd_fail;
    logic            uf_q;
    logic            ov_q;
    logic            uf_show_q;
    logic            show_pix;

    assign sof_evt = i_sof && i_wr_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Read handshake: i_read_request high in cycle n pops one pixel, which is
    // presented in cycle n+1; there is no back-pressure toward the consumer.
    always_comb begin
        state_d    = state_q;
        fifo_flush = 1'b0;
        fifo_wr    = 1'b0;
        fifo_rd    = 1'b0;
        start_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                fifo_wr = 1'b0;
            end
            S_PREFILL: begin
                fifo_wr = i_wr_valid;
                if (fifo_level >= LW'(PREFILL_LVL)) begin
                    state_d = S_STREAM;
                    start_d = 1'b1;
                end
            end
            S_STREAM: begin
                fifo_wr = i_wr_valid;
                fifo_rd = i_read_request;
                if (i_finish) begin
                    state_d    = S_IDLE;
                    fifo_flush = 1'b1;
                    fifo_wr    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Start of frame resynchronises from any state and outranks i_finish.
        if (sof_evt) begin
            state_d    = S_PREFILL;
            fifo_flush = 1'b1;
            fifo_wr    = 1'b1;
            fifo_rd    = 1'b0;
            start_d    = 1'b0;
        end
    end

    itp_pix_fifo #(
        .DEPTH (DEPTH),
        .W     (3 * CW)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .flush    (fifo_flush),
        .wr_en    (fifo_wr),
        .wr_data  ({i_wr_R, i_wr_G, i_wr_B}),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_rdata),
        .rd_valid (fifo_rvalid),
        .level    (fifo_level),
        .wr_drop  (wr_drop),
        .rd_fail  (rd_fail)
    );

    // A new error outranks a clear; a resync starts the frame with clean flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_q      <= 1'b0;
            uf_q      <= 1'b0;
            uf_show_q <= 1'b0;
        end else begin
            ov_q      <= wr_drop || (ov_q && !i_clr_err && !sof_evt);
            uf_q      <= rd_fail || (uf_q && !i_clr_err && !sof_evt);
            uf_show_q <= rd_fail;
        end
    end

`ifdef UNDERFLOW_REPEAT_EN
    assign show_pix = fifo_rvalid || uf_show_q;
`else
    assign show_pix = fifo_rvalid;
`endif

    assign {o_Red, o_Green, o_Blue} = show_pix ? fifo_rdata : '0;
    assign o_start     = start_q;
    assign o_level     = fifo_level;
    assign o_overflow  = ov_q;
    assign o_underflow = uf_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_itp_pixel_source.sv
// Directed bench for itp_pixel_source: driver tasks push expected pixels into
// exp_q; a negedge monitor pops and compares the served pixel stream.
module tb_itp_pixel_source;
    import itp_pkg::*;

    localparam int DEPTH = 1024;
    localparam int PRE   = 512;
    localparam int LW    = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          sof;
    logic [CW-1:0] wr_r, wr_g, wr_b;
    logic          read_request;
    logic          finish;
    logic          clr_err;
    logic          start;
    logic [CW-1:0] red, green, blue;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;
    state_t        state;

    int            checks = 0;
    int            errors = 0;
    int            start_cnt = 0;
    int            mode = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] model_q[$];
    logic [PW-1:0] last_served;
    logic [PW-1:0] mon_exp;
    logic          req_d;

    always #5 clk = ~clk;

    itp_pixel_source #(
        .DEPTH       (DEPTH),
        .PREFILL_LVL (PRE),
        .CW          (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_valid     (wr_valid),
        .i_sof          (sof),
        .i_wr_R         (wr_r),
        .i_wr_G         (wr_g),
        .i_wr_B         (wr_b),
        .i_read_request (read_request),
        .i_finish       (finish),
        .i_clr_err      (clr_err),
        .o_start        (start),
        .o_Red          (red),
        .o_Green        (green),
        .o_Blue         (blue),
        .o_level        (level),
        .o_overflow     (overflow),
        .o_underflow    (underflow),
        .o_state        (state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int k);
        logic [CW-1:0] v;
        v = k[CW-1:0];
        return pack_pixel(v, v ^ 10'h155, ~v);
    endfunction

    function automatic logic [PW-1:0] uf_value();
`ifdef UNDERFLOW_REPEAT_EN
        return last_served;
`else
        return '0;
`endif
    endfunction

    // Monitor: a read issued in cycle n is checked against exp_q in cycle n+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_d <= 1'b0;
        else        req_d <= read_request;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (start) start_cnt++;
            if (req_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_unexpected actual=%0h expected=none", {red, green, blue});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pix_read", {red, green, blue}, mon_exp);
                end
            end else begin
                check("pix_idle", {red, green, blue}, '0);
            end
        end
    end

    // One clock of stimulus; the reference FIFO decides what each read returns.
    task automatic do_cycle(input bit wv, input bit sf, input int k, input bit rd,
                            input bit clr, input bit fin);
        logic [PW-1:0] p;
        p = mk(k);
        wr_valid = wv;
        sof = sf;
        {wr_r, wr_g, wr_b} = p;
        read_request = rd;
        clr_err = clr;
        finish = fin;
        if (wv && sf) begin
            if (rd) exp_q.push_back('0);
            model_q.delete();
            last_served = '0;
            model_q.push_back(p);
            mode = 1;
        end else begin
            if (rd) begin
                if (mode != 2) begin
                    exp_q.push_back('0);
                end else if (model_q.size() == 0) begin
                    exp_q.push_back(uf_value());
                end else begin
                    last_served = model_q.pop_front();
                    exp_q.push_back(last_served);
                end
            end
            if (wv && mode != 0 && model_q.size() < DEPTH) model_q.push_back(p);
            if (fin && mode == 2) begin
                model_q.delete();
                last_served = '0;
                mode = 0;
            end
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        sof = 1'b0;
        read_request = 1'b0;
        clr_err = 1'b0;
        finish = 1'b0;
    endtask

    task automatic prefill(input int base, input string tag);
        do_cycle(1, 1, base, 0, 0, 0);
        check({tag, "_sof_level"}, level, 1);
        check({tag, "_sof_state"}, state, S_PREFILL);
        check({tag, "_sof_flags"}, {overflow, underflow}, 2'b00);
        for (int i = 1; i < PRE; i++) do_cycle(1, 0, base + i, i == 100, 0, 0);
        check({tag, "_prefill_level"}, level, PRE);
        check({tag, "_start_early"}, start, 0);
        check({tag, "_still_prefill"}, state, S_PREFILL);
        do_cycle(0, 0, 0, 0, 0, 0);
        check({tag, "_start_pulse"}, start, 1);
        check({tag, "_stream_state"}, state, S_STREAM);
        mode = 2;
        do_cycle(0, 0, 0, 0, 0, 0);
        check({tag, "_start_single"}, start, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0; sof = 1'b0; read_request = 1'b0;
        finish = 1'b0; clr_err = 1'b0;
        {wr_r, wr_g, wr_b} = '0;
        last_served = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_start", start, 0);
        check("rst_flags", {overflow, underflow}, 2'b00);
        check("rst_pix", {red, green, blue}, '0);
        check("rst_state", state, S_IDLE);
        rst_n = 1'b1;

        // Idle: plain writes and reads are ignored.
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 7 + i, 0, 0, 0);
        check("idle_wr_ignored", level, 0);
        do_cycle(0, 0, 0, 1, 0, 0);

        prefill(1, "first");

        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);
        check("after_3_reads_level", level, 509);

        // Fill to the brim, then overflow and read+write at full.
        for (int k = 0; k < 515; k++) do_cycle(1, 0, 2000 + k, 0, 0, 0);
        check("full_level", level, DEPTH);
        check("full_no_ovf", overflow, 0);
        do_cycle(1, 0, 3000, 0, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, DEPTH);
        do_cycle(1, 0, 3001, 1, 0, 0);
        check("full_rw_level", level, DEPTH);
        do_cycle(0, 0, 0, 0, 1, 0);
        check("ovf_cleared", overflow, 0);
        do_cycle(1, 0, 3002, 0, 1, 0);
        check("ovf_beats_clear", overflow, 1);
        do_cycle(0, 0, 0, 0, 1, 0);
        check("ovf_cleared2", overflow, 0);

        // Drain completely, then underflow.
        for (int i = 0; i < DEPTH; i++) do_cycle(0, 0, 0, 1, 0, 0);
        check("drained_level", level, 0);
        check("drained_no_uf", underflow, 0);
        do_cycle(0, 0, 0, 1, 0, 0);
        check("uf_set", underflow, 1);
        check("uf_level", level, 0);
        do_cycle(1, 0, 4000, 1, 0, 0);
        check("empty_rw_level", level, 1);
        do_cycle(0, 0, 0, 1, 0, 0);
        check("empty_rw_drain", level, 0);
        check("uf_sticky", underflow, 1);

        // Resync mid-stream re-prefills and clears flags.
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 5000 + i, 0, 0, 0);
        check("pre_resync_level", level, 3);
        prefill(6000, "resync");
        check("second_start", start_cnt, 2);

        do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1);
        check("finish_level", level, 0);
        check("finish_state", state, S_IDLE);
        do_cycle(0, 0, 0, 1, 0, 0);

        prefill(7000, "third");
        do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);
        check("pre_reset_level", level, PRE - 2);

        // Reset in the middle of streaming.
        rst_n = 1'b0;
        model_q.delete();
        last_served = '0;
        mode = 0;
        #1;
        check("midrst_level", level, 0);
        check("midrst_pix", {red, green, blue}, '0);
        check("midrst_start", start, 0);
        check("midrst_state", state, S_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(1, 0, 8000, 1, 0, 0);
        check("post_rst_level", level, 0);
        check("post_rst_state", state, S_IDLE);

        repeat (3) do_cycle(0, 0, 0, 0, 0, 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("start_total", start_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
